// File: rtl/udma_uart_tx_if.sv
// ---------------------------------------------------------------------------
// udma_uart_tx_if
//
// Byte stream from the uDMA TX channel into the UART transmitter.
// A byte moves on a cycle where valid and ready are both high.
//
// Signals
//   data   8  byte to transmit; bits above the frame's data-bit count are
//             ignored by the receiver of the stream
//   valid  1  data is valid (driven by the channel / master)
//   ready  1  transmitter can take the byte this cycle (driven by the slave)
// ---------------------------------------------------------------------------
interface udma_uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  // uDMA channel side
  modport master (
    output data,
    output valid,
    input  ready
  );

  // UART transmitter side
  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/udma_uart_tx.sv
// ---------------------------------------------------------------------------
// udma_uart_tx
//
// UART transmit serializer for the uDMA UART peripheral. Bytes arrive over a
// valid/ready stream and are shifted out LSB first as
//   start(0) | N data bits | optional even parity | 1 or 2 stop bits(1)
// with N = 5 + cfg_bits_i. Each bit lasts cfg_div_i+1 clock cycles. The whole
// frame configuration is captured together with the byte, so register writes
// made while a frame is on the line only affect the following frame.
// A new byte can be accepted on the final cycle of the last stop bit, which
// lets consecutive frames leave with no idle cycle between them.
//
// Ports
//   clk_i            in   1          peripheral clock
//   rstn_i           in   1          synchronous reset, active low
//   cfg_en_i         in   1          TX enable; gates acceptance of new bytes
//   cfg_div_i        in   DIV_WIDTH  baud divider, bit period = div+1 cycles
//   cfg_bits_i       in   2          data bits: 00=5 01=6 10=7 11=8
//   cfg_parity_en_i  in   1          append an even-parity bit
//   cfg_stop_bits_i  in   1          0 = one stop bit, 1 = two stop bits
//   tx_if            slave           byte stream (data / valid / ready)
//   tx_o             out  1          serial line, registered, idles high
//   busy_o           out  1          frame in progress (start .. last stop)
// ---------------------------------------------------------------------------
module udma_uart_tx #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,

  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_stop_bits_i,

  udma_uart_tx_if.slave        tx_if,

  output logic                 tx_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // -------------------------------------------------------------------------
  // State and per-frame registers
  // -------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q,  baud_cnt_d;   // cycles left in this bit
  logic [2:0]           bit_cnt_q,   bit_cnt_d;    // data bit index 0..N-1
  logic                 stop_cnt_q,  stop_cnt_d;   // 0 = first stop bit
  logic [7:0]           shift_q,     shift_d;      // bit 0 is the next data bit
  logic                 parity_q,    parity_d;     // even parity of the frame

  // Configuration captured with the byte
  logic [DIV_WIDTH-1:0] div_q,       div_d;
  logic [1:0]           bits_q,      bits_d;
  logic                 parity_en_q, parity_en_d;
  logic                 stop2_q,     stop2_d;

  logic                 tx_q,        tx_d;

  // -------------------------------------------------------------------------
  // Helper terms
  // -------------------------------------------------------------------------
  logic       bit_done;     // last cycle of the current bit period
  logic       last_data;    // current data bit is bit N-1
  logic       frame_slot;   // cycle on which a new frame may be started
  logic       accept;       // stream handshake this cycle
  logic [7:0] data_mask;
  logic [7:0] data_masked;

  assign bit_done  = (baud_cnt_q == '0);
  assign last_data = (bit_cnt_q == (3'd4 + {1'b0, bits_q}));

  // A new frame may begin from IDLE, or on the final cycle of the last stop
  // bit so that back-to-back frames keep the line continuously driven.
  assign frame_slot = (state_q == IDLE) ||
                      ((state_q == STOP) && bit_done && (!stop2_q || stop_cnt_q));

  // Ready is a function of state, counters and enable only, never of valid,
  // and is held low while reset is asserted.
  assign tx_if.ready = rstn_i && cfg_en_i && frame_slot;
  assign accept      = tx_if.ready && tx_if.valid;

  // Clear the unused upper bits at capture time; the parity bit is then the
  // XOR of the whole masked byte and the shifter never emits stray bits.
  always_comb begin
    case (cfg_bits_i)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  assign data_masked = tx_if.data & data_mask;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    div_d       = div_q;
    bits_d      = bits_q;
    parity_en_d = parity_en_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;

    // Baud counter: counts down inside a bit, reloaded below at bit ends.
    if (!bit_done) begin
      baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
      end

      START: begin
        if (bit_done) begin
          state_d    = DATA;
          baud_cnt_d = div_q;
          bit_cnt_d  = 3'd0;
          tx_d       = shift_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          baud_cnt_d = div_q;
          if (last_data) begin
            if (parity_en_q) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end

      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          baud_cnt_d = div_q;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end

      STOP: begin
        if (bit_done) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            baud_cnt_d = div_q;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A handshake (from IDLE or the last stop cycle) overrides the above and
    // starts the next frame with the configuration present right now.
    if (accept) begin
      state_d     = START;
      baud_cnt_d  = cfg_div_i;
      bit_cnt_d   = 3'd0;
      stop_cnt_d  = 1'b0;
      shift_d     = data_masked;
      parity_d    = ^data_masked;
      div_d       = cfg_div_i;
      bits_d      = cfg_bits_i;
      parity_en_d = cfg_parity_en_i;
      stop2_d     = cfg_stop_bits_i;
      tx_d        = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      // NOTE: the datapath registers are reset too, not only the FSM, so the
      // block restarts from one fully known state after an aborted frame.
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      div_q       <= '0;
      bits_q      <= 2'b00;
      parity_en_q <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      div_q       <= div_d;
      bits_q      <= bits_d;
      parity_en_q <= parity_en_d;
      stop2_q     <= stop2_d;
      tx_q        <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);

endmodule
